// File: rtl/div_pkg.sv
// Shared types and constants for the AXI-stream restoring divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_LAT   = DIV_WIDTH + 1;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_iter_step.sv
// One combinational radix-2 restoring step on unsigned magnitudes.
module div_iter_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic           fits;

    // The true difference is below 2^WIDTH whenever it is kept, so WIDTH-bit subtraction suffices.
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        fits    = shifted >= {1'b0, dvsr_i};
        if (fits) begin
            rem_o = shifted[WIDTH-1:0] - dvsr_i;
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = shifted[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_axis_responder.sv
// AXI-stream divider responder: holds operands, runs WIDTH restoring steps,
// then pulses {quotient, remainder} for one cycle.
module div_axis_responder
    import div_pkg::*;
#(
    parameter int unsigned WIDTH  = DIV_WIDTH,
    parameter bit          SIGNED = 1'b1
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               s_axis_dividend_tvalid,
    output logic               s_axis_dividend_tready,
    input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
    input  logic               s_axis_divisor_tvalid,
    output logic               s_axis_divisor_tready,
    input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
    output logic               m_axis_dout_tvalid,
    output logic [2*WIDTH-1:0] m_axis_dout_tdata
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    div_state_e           state_q, state_d;
    logic                 hold_a_q, hold_a_d, hold_b_q, hold_b_d;
    logic [WIDTH-1:0]     a_hold_q, a_hold_d, b_hold_q, b_hold_d;
    logic [WIDTH-1:0]     rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic                 tvalid_q, tvalid_d;
    logic [2*WIDTH-1:0]   tdata_q, tdata_d;

    logic                 a_rdy, b_rdy, a_hs, b_hs, a_neg, b_neg;
    logic [WIDTH-1:0]     a_val, b_val, step_rem, step_quo;

    assign a_rdy = (state_q == IDLE) && !hold_a_q;
    assign b_rdy = (state_q == IDLE) && !hold_b_q;

    assign s_axis_dividend_tready = a_rdy;
    assign s_axis_divisor_tready  = b_rdy;
    assign m_axis_dout_tvalid     = tvalid_q;
    assign m_axis_dout_tdata      = tdata_q;

    div_iter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (dvsr_q),
        .rem_o  (step_rem),
        .quo_o  (step_quo)
    );

    always_comb begin
        state_d  = state_q;
        hold_a_d = hold_a_q;
        hold_b_d = hold_b_q;
        a_hold_d = a_hold_q;
        b_hold_d = b_hold_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        cnt_d    = cnt_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        tvalid_d = 1'b0;
        tdata_d  = tdata_q;

        a_hs  = s_axis_dividend_tvalid && a_rdy;
        b_hs  = s_axis_divisor_tvalid && b_rdy;
        a_val = hold_a_q ? a_hold_q : s_axis_dividend_tdata;
        b_val = hold_b_q ? b_hold_q : s_axis_divisor_tdata;
        a_neg = SIGNED && a_val[WIDTH-1];
        b_neg = SIGNED && b_val[WIDTH-1];

        case (state_q)
            IDLE: begin
                if ((hold_a_q || a_hs) && (hold_b_q || b_hs)) begin
                    state_d  = CALC;
                    hold_a_d = 1'b0;
                    hold_b_d = 1'b0;
                    rem_d    = '0;
                    quo_d    = a_neg ? -a_val : a_val;
                    dvsr_d   = b_neg ? -b_val : b_val;
                    cnt_d    = '0;
                    q_neg_d  = a_neg ^ b_neg;
                    r_neg_d  = a_neg;
                end else begin
                    // Lone operand waits in its hold register until its partner shows up.
                    if (a_hs) begin
                        a_hold_d = s_axis_dividend_tdata;
                        hold_a_d = 1'b1;
                    end
                    if (b_hs) begin
                        b_hold_d = s_axis_divisor_tdata;
                        hold_b_d = 1'b1;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d  = DONE;
                    tvalid_d = 1'b1;
                    tdata_d  = {q_neg_q ? -step_quo : step_quo,
                                r_neg_q ? -step_rem : step_rem};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            hold_a_q <= 1'b0;
            hold_b_q <= 1'b0;
            a_hold_q <= '0;
            b_hold_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            cnt_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            hold_a_q <= hold_a_d;
            hold_b_q <= hold_b_d;
            a_hold_q <= a_hold_d;
            b_hold_q <= b_hold_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            cnt_q    <= cnt_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
        end
    end

endmodule
